sipo_deserializer: RTL and testbench

//  Serial-in/parallel-out front end for the 4-bit PIPO holding register.

---
 rtl/sipo_deserializer.sv | 112 +++++++++++
 tb/tb_sipo_deserializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in/parallel-out front end for a PIPO holding register.
// A frame is armed by start, and then WIDTH bits qualified by ser_valid are collected.
// The finished word is presented on par_out with a one-cycle word_valid pulse.
// A start arriving mid-frame throws away the partial word and pulses abort.

module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             word_valid,
    output logic             busy,
    output logic             abort
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             wv_q, wv_d;
    logic             abort_q, abort_d;
    logic [WIDTH-1:0] shiftWord;

    // Shift register contents after taking in the current ser_in bit, in the configured bit order
    always_comb begin
        if (MSB_FIRST) begin
            shiftWord = {sreg_q[WIDTH-2:0], ser_in};
        end else begin
            shiftWord = {ser_in, sreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic for the frame FSM, the bit counter, the shift register and the output pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        par_d   = par_q;
        wv_d    = 1'b0;
        abort_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end

            SHIFT: begin
                if (ser_valid && (cnt_q == LAST)) begin
                    par_d   = shiftWord;
                    wv_d    = 1'b1;
                    cnt_d   = '0;
                    sreg_d  = '0;
                    state_d = start ? SHIFT : IDLE;
                end else if (start) begin
                    cnt_d   = '0;
                    sreg_d  = '0;
                    abort_d = 1'b1;
                end else if (ser_valid) begin
                    sreg_d = shiftWord;
                    cnt_d  = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a mid-frame reset drops everything
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            par_q   <= '0;
            wv_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            par_q   <= par_d;
            wv_q    <= wv_d;
            abort_q <= abort_d;
        end
    end

    assign par_out    = par_q;
    assign word_valid = wv_q;
    assign abort      = abort_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
// Drives one MSB-first and one LSB-first deserializer from the same serial stream.
// Each frame sent pushes the expected word for both bit orders onto per-DUT queues.
// A monitor pops and compares a word every time a DUT pulses word_valid.

module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         start;
    logic         ser_in;
    logic         ser_valid;
    logic [W-1:0] parM, parL;
    logic         wvM, wvL, busyM, busyL, abM, abL;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] qM[$];
    logic [W-1:0] qL[$];

    int wvCountM    = 0;
    int wvCountL    = 0;
    int abortCountM = 0;
    int cycleCnt    = 0;
    int lastWvCycle = 0;
    int wvGap       = 0;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .par_out   (parM),
        .word_valid(wvM),
        .busy      (busyM),
        .abort     (abM)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .par_out   (parL),
        .word_valid(wvL),
        .busy      (busyL),
        .abort     (abL)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to measure the spacing of word_valid pulses
    always @(posedge clk) cycleCnt++;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Bit-reverse a word; the LSB-first DUT sees the same stream mirrored
    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    // Drive one cycle of inputs, applied on the falling edge
    task automatic applyStimulus(input logic st, input logic si, input logic sv);
        @(negedge clk);
        start     = st;
        ser_in    = si;
        ser_valid = sv;
    endtask

    // Settle just after the next rising edge before looking at outputs
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Send word w with w[W-1] first, an optional gap after bit index gapAfter and an optional start on the final bit
    task automatic sendFrame(input logic [W-1:0] w, input bit doStart, input int gapAfter,
                             input int gapLen, input bit startOnLast);
        if (doStart) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                qM.push_back(w);
                qL.push_back(rev(w));
                applyStimulus(startOnLast, w[W-1-i], 1'b1);
            end else begin
                applyStimulus(1'b0, w[W-1-i], 1'b1);
            end
            if (i == gapAfter) begin
                for (int g = 0; g < gapLen; g++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    // Scoreboard monitor: pops an expected word on each word_valid pulse
    always @(negedge clk) begin
        if (clear_n) begin
            if (wvM) begin
                wvCountM++;
                wvGap       = cycleCnt - lastWvCycle;
                lastWvCycle = cycleCnt;
                if (qM.size() == 0) checkOutput("unexpected word_valid msb", 1, 0);
                else checkOutput("par_out msb", {28'd0, parM}, {28'd0, qM.pop_front()});
                checkOutput("word_valid with abort msb", {31'd0, abM}, 0);
            end
            if (wvL) begin
                wvCountL++;
                if (qL.size() == 0) checkOutput("unexpected word_valid lsb", 1, 0);
                else checkOutput("par_out lsb", {28'd0, parL}, {28'd0, qL.pop_front()});
            end
            if (abM) abortCountM++;
        end
    end

    // Directed sequences followed by a few randomised frames
    initial begin
        int wvBefore;
        int abBefore;
        int busyLow;
        logic [2*W-1:0] seq;

        clear_n   = 1'b0;
        start     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;

        // Reset held with inputs toggling randomly
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            settle();
        end
        checkOutput("reset par_out msb", {28'd0, parM}, 0);
        checkOutput("reset par_out lsb", {28'd0, parL}, 0);
        checkOutput("reset word_valid", {31'd0, wvM}, 0);
        checkOutput("reset busy", {31'd0, busyM}, 0);
        checkOutput("reset abort", {31'd0, abM}, 0);

        // Release without start: serial activity is ignored
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        settle();
        checkOutput("idle par_out", {28'd0, parM}, 0);
        checkOutput("idle busy", {31'd0, busyM}, 0);
        checkOutput("idle word_valid count", wvCountM, 0);

        // Plain frame 0110 with one-cycle latency and busy falling
        sendFrame(4'b0110, 1'b1, -1, 0, 1'b0);
        settle();
        checkOutput("frame1 word_valid", {31'd0, wvM}, 1);
        checkOutput("frame1 busy fall", {31'd0, busyM}, 0);
        checkOutput("frame1 par_out", {28'd0, parM}, 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("frame1 word_valid one cycle", {31'd0, wvM}, 0);
        checkOutput("frame1 par_out held", {28'd0, parM}, 4'b0110);

        // Frame 1110 with a two-cycle gap mid-frame
        wvBefore = wvCountM;
        sendFrame(4'b1110, 1'b1, 1, 2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("gap frame par_out", {28'd0, parM}, 4'b1110);
        checkOutput("gap frame single word_valid", wvCountM - wvBefore, 1);

        // Restart after two bits: abort pulse, par_out untouched, then 1001
        wvBefore = wvCountM;
        abBefore = abortCountM;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        settle();
        checkOutput("restart abort pulse", {31'd0, abM}, 1);
        checkOutput("restart par_out unchanged", {28'd0, parM}, 4'b1110);
        checkOutput("restart busy", {31'd0, busyM}, 1);
        sendFrame(4'b1001, 1'b0, -1, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("restart abort count", abortCountM - abBefore, 1);
        checkOutput("restart word count", wvCountM - wvBefore, 1);
        checkOutput("restart par_out msb", {28'd0, parM}, 4'b1001);
        checkOutput("restart par_out lsb", {28'd0, parL}, 4'b1001);

        // Back-to-back frames 0110 then 1110 with start on the final bit
        busyLow = 0;
        abBefore = abortCountM;
        seq = 8'b0110_1110;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * W; i++) begin
            if (i == W - 1) begin
                qM.push_back(4'b0110);
                qL.push_back(rev(4'b0110));
            end
            if (i == 2 * W - 1) begin
                qM.push_back(4'b1110);
                qL.push_back(rev(4'b1110));
            end
            applyStimulus(i == W - 1, seq[2*W-1-i], 1'b1);
            settle();
            if (i < 2 * W - 1 && busyM !== 1'b1) busyLow++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("back-to-back busy held", busyLow, 0);
        checkOutput("back-to-back word_valid spacing", wvGap, 4);
        checkOutput("back-to-back no abort", abortCountM - abBefore, 0);
        checkOutput("back-to-back final par_out", {28'd0, parM}, 4'b1110);
        checkOutput("back-to-back busy fall", {31'd0, busyM}, 0);

        // Bits 1,1,0,0: LSB-first instance assembles 0011
        sendFrame(4'b1100, 1'b1, -1, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("lsb-first par_out", {28'd0, parL}, 4'b0011);
        checkOutput("msb-first par_out", {28'd0, parM}, 4'b1100);

        // Reset after two bits: partial word lost, later bits ignored until start
        wvBefore = wvCountM;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        clear_n = 1'b0;
        settle();
        checkOutput("midframe reset par_out msb", {28'd0, parM}, 0);
        checkOutput("midframe reset par_out lsb", {28'd0, parL}, 0);
        checkOutput("midframe reset busy", {31'd0, busyM}, 0);
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < W + 1; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("post-reset no word_valid", wvCountM - wvBefore, 0);
        checkOutput("post-reset par_out", {28'd0, parM}, 0);
        checkOutput("post-reset busy", {31'd0, busyM}, 0);

        // Randomised frames with random gaps
        for (int f = 0; f < 8; f++) begin
            sendFrame(4'($urandom_range(0, 15)), 1'b1, $urandom_range(0, W - 2), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("msb queue drained", qM.size(), 0);
        checkOutput("lsb queue drained", qL.size(), 0);
        checkOutput("word counts agree", wvCountM, wvCountL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
